// File: rtl/ram_if.sv
// Arbiter <-> RAM responder request bus: fixed-latency busy/done handshake.
interface ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic              ramBUSY;
    logic [DATA_W-1:0] ramload;
    logic              ram_err;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramBUSY, ramload, ram_err
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramBUSY, ramload, ram_err
    );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed on-chip RAM behind a fixed-latency busy/done handshake.
// One access at a time: IDLE -> ACCESS (LATENCY cycles busy) -> DONE (one cycle) -> IDLE.
module ram_responder #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 4096,
    parameter int                LATENCY     = 2,
    parameter logic [DATA_W-1:0] OOR_PATTERN = 32'hBAD1BAD1
) (
    input  logic  CLK,
    input  logic  RST,
    ram_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int HI = 2 + IW;
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              op_wr;
    logic              oor_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] mem [DEPTH];

    // Any byte-address bit above the word index makes the access out of range.
    logic [ADDR_W-1:0] addr_hi;
    logic              oor_in;
    logic              req;
    logic              last;
    logic              mem_we;

    assign addr_hi = bus.ramaddr >> HI;
    assign oor_in  = |addr_hi;
    assign req     = bus.ramWEN | bus.ramREN;
    assign last    = (state == ACCESS) && (cnt == '0);
    // Reset wins over the commit edge so an aborted write never lands.
    assign mem_we  = last && op_wr && !oor_q && !RST;

    // Byte-offset bits are intentionally ignored: accesses are whole words.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.ramaddr[1:0]};

    always_ff @(posedge CLK) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            oor_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            bus.ramBUSY <= 1'b0;
            bus.ramload <= '0;
            bus.ram_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.ram_err <= 1'b0;
                    if (req) begin
                        op_wr       <= bus.ramWEN;
                        oor_q       <= oor_in;
                        idx_q       <= bus.ramaddr[2 +: IW];
                        wdata_q     <= bus.ramstore;
                        cnt         <= CW'(LATENCY - 1);
                        bus.ramBUSY <= 1'b1;
                        state       <= ACCESS;
                    end else begin
                        bus.ramBUSY <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt         <= cnt - 1'b1;
                        bus.ramBUSY <= 1'b1;
                    end else begin
                        if (!op_wr) bus.ramload <= oor_q ? OOR_PATTERN : mem[idx_q];
                        bus.ram_err <= oor_q;
                        bus.ramBUSY <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Requests seen here belong to the access just finished.
                    bus.ram_err <= 1'b0;
                    bus.ramBUSY <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    bus.ram_err <= 1'b0;
                    bus.ramBUSY <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: LATENCY 2 main instance plus LATENCY 1 and 15 instances.
module tb_ram_responder;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        ren   [3];
    logic        wen   [3];
    logic [31:0] addr  [3];
    logic [31:0] store [3];
    logic        busy  [3];
    logic [31:0] load  [3];
    logic        err   [3];

    int n_vec = 0;
    int n_bad = 0;

    ram_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    ram_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    ram_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus0.ramREN = ren[0]; assign bus0.ramWEN = wen[0];
    assign bus0.ramaddr = addr[0]; assign bus0.ramstore = store[0];
    assign busy[0] = bus0.ramBUSY; assign load[0] = bus0.ramload; assign err[0] = bus0.ram_err;
    assign bus1.ramREN = ren[1]; assign bus1.ramWEN = wen[1];
    assign bus1.ramaddr = addr[1]; assign bus1.ramstore = store[1];
    assign busy[1] = bus1.ramBUSY; assign load[1] = bus1.ramload; assign err[1] = bus1.ram_err;
    assign bus2.ramREN = ren[2]; assign bus2.ramWEN = wen[2];
    assign bus2.ramaddr = addr[2]; assign bus2.ramstore = store[2];
    assign busy[2] = bus2.ramBUSY; assign load[2] = bus2.ramload; assign err[2] = bus2.ram_err;

    ram_responder #(.LATENCY(2))  dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    ram_responder #(.LATENCY(1))  dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
    ram_responder #(.LATENCY(15)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access, hold it until busy drops, sample DONE, return with the DUT back in IDLE.
    task automatic access(input int d, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] s, output int blen, output logic [31:0] ld,
                          output logic e);
        int n = 0;
        @(negedge CLK);
        wen[d] = w; ren[d] = r; addr[d] = a; store[d] = s;
        @(posedge CLK); #1;
        while (busy[d] === 1'b1 && n < 40) begin
            n++;
            @(posedge CLK); #1;
        end
        ld = load[d]; e = err[d];
        wen[d] = 1'b0; ren[d] = 1'b0;
        blen = n;
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int          bl;
        logic [31:0] ld, ld_a, ld_b;
        logic        e;
        logic [7:0]  bp;

        for (int i = 0; i < 3; i++) begin
            ren[i] = 0; wen[i] = 0; addr[i] = '0; store[i] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_load", load[0], 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        RST = 1'b0;

        access(0, 1, 0, 32'h40, 32'hDEADBEEF, bl, ld, e);
        chk("wr40_busylen", 32'(bl), 32'd2);
        chk("wr40_err", 32'(e), 32'd0);
        access(0, 0, 1, 32'h40, 32'h0, bl, ld, e);
        chk("rd40_busylen", 32'(bl), 32'd2);
        chk("rd40_data", ld, 32'hDEADBEEF);
        chk("rd40_err", 32'(e), 32'd0);
        access(0, 0, 1, 32'h43, 32'h0, bl, ld, e);
        chk("rd43_byteoff", ld, 32'hDEADBEEF);

        access(0, 1, 1, 32'h10, 32'h12345678, bl, ld, e);
        chk("both10_busylen", 32'(bl), 32'd2);
        access(0, 0, 1, 32'h10, 32'h0, bl, ld, e);
        chk("both10_wr_wins", ld, 32'h12345678);

        access(0, 1, 0, 32'h0, 32'hCAFEF00D, bl, ld, e);
        access(0, 0, 1, 32'h0001_0000, 32'h0, bl, ld, e);
        chk("oor_rd_data", ld, 32'hBAD1BAD1);
        chk("oor_rd_err", 32'(e), 32'd1);
        chk("oor_err_pulse", 32'(err[0]), 32'd0);
        access(0, 1, 0, 32'h0001_0000, 32'h55, bl, ld, e);
        chk("oor_wr_err", 32'(e), 32'd1);
        access(0, 0, 1, 32'h0, 32'h0, bl, ld, e);
        chk("oor_wr_dropped", ld, 32'hCAFEF00D);

        // Request held continuously across two accesses; address switched during DONE.
        @(negedge CLK);
        ren[0] = 1'b1; addr[0] = 32'h40;
        ld_a = '0; ld_b = '0; bp = '0;
        @(posedge CLK); #1;
        for (int c = 1; c <= 8; c++) begin
            bp[c-1] = busy[0];
            if (c == 3) begin ld_a = load[0]; addr[0] = 32'h10; end
            if (c == 7) begin ld_b = load[0]; ren[0] = 1'b0; end
            if (c < 8) begin @(posedge CLK); #1; end
        end
        chk("b2b_busy_pattern", 32'(bp), 32'h33);
        chk("b2b_first_data", ld_a, 32'hDEADBEEF);
        chk("b2b_second_data", ld_b, 32'h12345678);

        // Reset in the first ACCESS cycle aborts the pending write.
        access(0, 1, 0, 32'h80, 32'h11112222, bl, ld, e);
        @(negedge CLK);
        wen[0] = 1'b1; addr[0] = 32'h80; store[0] = 32'hAAAA5555;
        @(posedge CLK); #1;
        chk("abort_busy_before", 32'(busy[0]), 32'd1);
        RST = 1'b1; wen[0] = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("abort_busy_after", 32'(busy[0]), 32'd0);
        access(0, 0, 1, 32'h80, 32'h0, bl, ld, e);
        chk("abort_no_commit", ld, 32'h11112222);

        access(1, 1, 0, 32'h24, 32'h0F0F1234, bl, ld, e);
        chk("lat1_wr_busylen", 32'(bl), 32'd1);
        access(1, 0, 1, 32'h24, 32'h0, bl, ld, e);
        chk("lat1_rd_busylen", 32'(bl), 32'd1);
        chk("lat1_rd_data", ld, 32'h0F0F1234);

        access(2, 1, 0, 32'h3FFC, 32'h89ABCDEF, bl, ld, e);
        chk("lat15_wr_busylen", 32'(bl), 32'd15);
        access(2, 0, 1, 32'h3FFC, 32'h0, bl, ld, e);
        chk("lat15_rd_busylen", 32'(bl), 32'd15);
        chk("lat15_rd_data", ld, 32'h89ABCDEF);
        chk("lat15_rd_err", 32'(e), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
